// File: rtl/phase_pkg.sv
// Shared types and constants for the phase-difference datapath.
// Phases are signed Q8.10 radians: 19 bits, 1 LSB = 1/1024 rad.
package phase_pkg;

  localparam int WIDTH    = 19;
  localparam int FRAC     = 10;
  localparam int PI_Q     = 3217;
  localparam int TWO_PI_Q = 6434;

  typedef logic signed [WIDTH-1:0] phase_t;
  typedef logic signed [WIDTH:0]   phase_ext_t;

endpackage

// File: rtl/phase_wrap.sv
// Wraps a widened phase into [-PI_Q, +PI_Q] with one correction step,
// then saturates to phase_t. Ports: i_d (phase_ext_t) -> o_w (phase_t).
module phase_wrap
  import phase_pkg::*;
(
  input  phase_ext_t i_d,
  output phase_t     o_w
);

  localparam int XW = WIDTH + 2;

  localparam logic signed [XW-1:0] PI_X  =
    XW'(PI_Q);
  localparam logic signed [XW-1:0] NPI_X =
    -PI_X;
  localparam logic signed [XW-1:0] TPI_X =
    XW'(TWO_PI_Q);
  localparam logic signed [XW-1:0] MAX_X =
    XW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] MIN_X =
    -MAX_X - XW'(1);

  logic signed [XW-1:0] w_d;
  logic signed [XW-1:0] w_w;

  // One extra guard bit so the correction can never overflow.
  assign w_d = {i_d[WIDTH], i_d};

  always_comb begin
    w_w = w_d;
    if (w_d > PI_X)
      w_w = w_d - TPI_X;
    else if (w_d < NPI_X)
      w_w = w_d + TPI_X;
  end

  // Only out-of-range inputs can push w_w outside phase_t.
  always_comb begin
    o_w = w_w[WIDTH-1:0];
    if (w_w > MAX_X)
      o_w = MAX_X[WIDTH-1:0];
    else if (w_w < MIN_X)
      o_w = MIN_X[WIDTH-1:0];
  end

endmodule

// File: rtl/phase_diff.sv
// Two-stage pipeline computing out = wrap(A - B) in Q8.10 radians.
// Ports: clk, rst (async high), in_valid, A, B -> out_valid, out.
module phase_diff
  import phase_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  phase_t A,
  input  phase_t B,
  output logic   out_valid,
  output phase_t out
);

  phase_ext_t w_diff;
  phase_t     w_wrap;

  phase_ext_t r_d;
  logic       r_v1;
  phase_t     r_out;
  logic       r_ov;

  // Difference at WIDTH+1 bits is always exact.
  assign w_diff = {A[WIDTH-1], A}
                - {B[WIDTH-1], B};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d  <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_d  <= w_diff;
      r_v1 <= in_valid;
    end
  end

  phase_wrap u_wrap (
    .i_d (r_d),
    .o_w (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
      r_ov  <= 1'b0;
    end else begin
      r_out <= w_wrap;
      r_ov  <= r_v1;
    end
  end

  assign out       = r_out;
  assign out_valid = r_ov;

endmodule

// File: tb/tb_phase_diff.sv
// Self-checking bench for phase_diff: scoreboard queue of expected
// results, popped by a negedge monitor when out_valid is high.
module tb_phase_diff;
  import phase_pkg::*;

  logic   clk;
  logic   rst;
  logic   in_valid;
  phase_t A;
  phase_t B;
  logic   out_valid;
  phase_t out;

  int checks = 0;
  int errors = 0;
  int q[$];
  bit mon_en = 0;
  logic [1:0] vh;

  phase_diff dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int golden(input int a, input int b);
    int d;
    d = a - b;
    if (d > 3217)
      d = d - 6434;
    else if (d < -3217)
      d = d + 6434;
    if (d > 262143) d = 262143;
    if (d < -262144) d = -262144;
    return d;
  endfunction

  // Expected out_valid: in_valid delayed by two clock edges.
  always @(posedge clk or posedge rst) begin
    if (rst) vh <= 2'b00;
    else     vh <= {vh[0], in_valid};
  end

  always @(negedge clk) begin
    int got;
    int e;
    if (!rst && mon_en) begin
      checks++;
      if (out_valid !== vh[1]) begin
        errors++;
        $display("FAIL valid_delay got=%b exp=%b",
                 out_valid, vh[1]);
      end
      if (out_valid === 1'b1) begin
        got = out;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got=%0d exp=none",
                   got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL out_value got=%0d exp=%0d",
                     got, e);
          end
        end
      end
    end
  end

  task automatic drive(input int a, input int b,
                       input bit v);
    A = phase_t'(a);
    B = phase_t'(b);
    in_valid = v;
    if (v) q.push_back(golden(a, b));
    @(posedge clk); #1;
  endtask

  task automatic drive_exp(input int a, input int b,
                           input int exp_v);
    A = phase_t'(a);
    B = phase_t'(b);
    in_valid = 1'b1;
    q.push_back(exp_v);
    @(posedge clk); #1;
  endtask

  task automatic flush(input int n);
    repeat (n) drive(0, 0, 1'b0);
  endtask

  task automatic test_reset;
    int got;
    rst = 1; in_valid = 1; A = 1000; B = 0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (out !== '0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got=%0d/%b exp=0/0",
                 out, out_valid);
      end
    end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_lat1 got=%b exp=0", out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    got = out;
    checks++;
    if (out_valid !== 1'b1 || got !== 1000) begin
      errors++;
      $display("FAIL first_lat2 got=%0d/%b exp=1000/1",
               got, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1;
  endtask

  task automatic test_no_wrap;
    drive_exp(1024, 512, 512);
    drive_exp(-2048, -1024, -1024);
    flush(3);
  endtask

  task automatic test_pos_wrap;
    drive_exp(3000, -3000, -434);
    drive_exp(3217, -3217, 0);
    flush(3);
  endtask

  task automatic test_neg_wrap;
    drive_exp(-3000, 3000, 434);
    drive_exp(3217, 0, 3217);
    drive_exp(-3217, 0, -3217);
    drive_exp(-3217, 3217, 0);
    flush(3);
  endtask

  task automatic test_saturation;
    drive_exp(262143, -262144, 262143);
    drive_exp(-262144, 262143, -262144);
    flush(3);
  endtask

  task automatic test_back_to_back;
    int a;
    int b;
    for (int i = 0; i < 8000; i++) begin
      a = int'($urandom_range(6434)) - 3217;
      b = int'($urandom_range(6434)) - 3217;
      drive(a, b, 1'b1);
    end
    flush(3);
  endtask

  task automatic test_valid_toggle;
    int a;
    int b;
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(6434)) - 3217;
      b = int'($urandom_range(6434)) - 3217;
      drive(a, b, 1'($urandom_range(1)));
    end
    flush(3);
  endtask

  task automatic test_reset_mid;
    drive(100, 50, 1'b1);
    drive(200, 50, 1'b1);
    rst = 1;
    q.delete();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset_mid got=%0d/%b exp=0/0",
               out, out_valid);
    end
    @(posedge clk); #1;
    rst = 0;
    flush(3);
    drive_exp(10, 20, -10);
    flush(3);
  endtask

  initial begin
    rst = 1; in_valid = 0; A = '0; B = '0;
    test_reset;
    test_no_wrap;
    test_pos_wrap;
    test_neg_wrap;
    test_saturation;
    test_back_to_back;
    test_valid_toggle;
    test_reset_mid;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
